// File: rtl/seq_detect_scheduler.sv
// Round-robin time-multiplexed Moore sequence detector over NUM_CH serial channels.
// Optional per-channel hit counters are built when SEQ_DET_HITCNT_EN is defined.
module seq_detect_scheduler #(
    parameter int              NUM_CH      = 4,
    parameter int              PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011,
    parameter int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_bit,
    output logic [NUM_CH-1:0] ch_ready,
    input  logic              cfg_valid,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    output logic              cfg_ready,
    output logic              det_valid,
    output logic [CH_W-1:0]   det_ch,
    input  logic [CH_W-1:0]   stat_sel,
    output logic [7:0]        stat_count
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        state;
    logic [CH_W-1:0]   rr;
    logic [CH_W-1:0]   flush_cnt;
    logic [PAT_W-1:0]  pattern;
    logic              overlap;

    logic [PAT_W-1:0]  hist [NUM_CH];
    logic [FILL_W-1:0] fill [NUM_CH];

    logic              cfg_accept;
    logic              xfer;
    logic              hit;
    logic              found;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   arb_idx;
    logic [PAT_W-1:0]  cand;

    assign cfg_ready  = (state != ST_FLUSH);
    assign cfg_accept = cfg_valid & cfg_ready;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        ch_ready = '0;
        gnt_idx  = '0;
        arb_idx  = '0;
        found    = 1'b0;
        if (state != ST_FLUSH && !cfg_accept) begin
            for (int off = 1; off <= NUM_CH; off++) begin
                arb_idx = CH_W'((int'(rr) + off) % NUM_CH);
                if (!found && ch_valid[arb_idx]) begin
                    found             = 1'b1;
                    ch_ready[arb_idx] = 1'b1;
                    gnt_idx           = arb_idx;
                end
            end
        end
    end

    assign xfer = |(ch_valid & ch_ready);
    assign cand = {hist[gnt_idx][PAT_W-2:0], ch_bit[gnt_idx]};
    assign hit  = xfer && (fill[gnt_idx] >= FILL_W'(PAT_W - 1)) && (cand == pattern);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            rr        <= CH_W'(NUM_CH - 1);
            pattern   <= DEFAULT_PAT;
            overlap   <= 1'b1;
        end else begin
            if (xfer)
                rr <= gnt_idx;
            if (cfg_accept) begin
                pattern <= cfg_pattern;
                overlap <= cfg_overlap;
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_accept) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end else if (|ch_valid) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cfg_accept) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end else if (ch_valid == '0) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == CH_W'(NUM_CH - 1)) begin
                        state     <= ST_IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the context memory is reset explicitly because a mid-stream reset must drop all history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
            end
        end else if (state == ST_FLUSH) begin
            hist[flush_cnt] <= '0;
            fill[flush_cnt] <= '0;
        end else if (xfer) begin
            if (hit && !overlap) begin
                hist[gnt_idx] <= '0;
                fill[gnt_idx] <= '0;
            end else begin
                hist[gnt_idx] <= cand;
                if (fill[gnt_idx] != FILL_W'(PAT_W))
                    fill[gnt_idx] <= fill[gnt_idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            det_valid <= 1'b0;
            det_ch    <= '0;
        end else begin
            det_valid <= hit;
            if (hit)
                det_ch <= gnt_idx;
        end
    end

`ifdef SEQ_DET_HITCNT_EN
    logic [7:0] hit_cnt [NUM_CH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++)
                hit_cnt[i] <= '0;
        end else if (state == ST_FLUSH) begin
            hit_cnt[flush_cnt] <= '0;
        end else if (hit && hit_cnt[gnt_idx] != 8'hFF) begin
            hit_cnt[gnt_idx] <= hit_cnt[gnt_idx] + 8'd1;
        end
    end

    assign stat_count = (int'(stat_sel) < NUM_CH) ? hit_cnt[stat_sel] : 8'd0;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = 8'd0;
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed self-checking bench for seq_detect_scheduler (NUM_CH=4, PAT_W=4).
module tb_seq_detect_scheduler;

    localparam int NUM_CH = 4;
    localparam int PAT_W  = 4;
    localparam int CH_W   = 2;

    logic              clock;
    logic              reset;
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_bit;
    logic [NUM_CH-1:0] ch_ready;
    logic              cfg_valid;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              cfg_overlap;
    logic              cfg_ready;
    logic              det_valid;
    logic [CH_W-1:0]   det_ch;
    logic [CH_W-1:0]   stat_sel;
    logic [7:0]        stat_count;

    int n_cmp = 0;
    int n_err = 0;

    seq_detect_scheduler #(
        .NUM_CH     (NUM_CH),
        .PAT_W      (PAT_W),
        .DEFAULT_PAT(4'b1011)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ch_valid   (ch_valid),
        .ch_bit     (ch_bit),
        .ch_ready   (ch_ready),
        .cfg_valid  (cfg_valid),
        .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap),
        .cfg_ready  (cfg_ready),
        .det_valid  (det_valid),
        .det_ch     (det_ch),
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Starts and ends at a falling edge.
    task automatic apply_reset();
        reset       = 1'b0;
        ch_valid    = '0;
        ch_bit      = '0;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_overlap = 1'b0;
        stat_sel    = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Offers one bit on one channel, waits for the handshake, returns det outputs of the next cycle.
    task automatic send_bit(input int ch, input logic b, output logic det, output logic [CH_W-1:0] dch);
        int waited = 0;
        ch_valid   = 4'b0001 << ch;
        ch_bit     = '0;
        ch_bit[ch] = b;
        #1;
        while (!ch_ready[ch] && waited < 20) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!ch_ready[ch]) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: ch%0d got ch_ready=%b required grant", ch, ch_ready);
            ch_valid = '0;
            det      = 1'b0;
            dch      = '0;
            @(negedge clock);
        end else begin
            @(posedge clock);
            @(negedge clock);
            ch_valid = '0;
            det      = det_valid;
            dch      = det_ch;
        end
    endtask

    // Issues a config with all channels requesting, then checks the FLUSH window.
    task automatic do_cfg(input logic [PAT_W-1:0] p, input logic ov);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_overlap = ov;
        ch_valid    = 4'hF;
        ch_bit      = '0;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_accept_ready: got %b required 1", cfg_ready);
        end
        n_cmp++;
        if (ch_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL cfg_accept_no_grant: got %b required 0000", ch_ready);
        end
        @(negedge clock);
        cfg_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            #1;
            n_cmp++;
            if (cfg_ready !== 1'b0 || ch_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL flush_cycle%0d: got cfg_ready=%b ch_ready=%b required 0 0000", k, cfg_ready, ch_ready);
            end
            @(negedge clock);
        end
        ch_valid = '0;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_end_ready: got %b required 1", cfg_ready);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++;
        if (det_valid !== 1'b0 || det_ch !== 2'd0) begin
            n_err++;
            $display("FAIL reset_det: got valid=%b ch=%0d required 0 0", det_valid, det_ch);
        end
        n_cmp++;
        if (cfg_ready !== 1'b1 || ch_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready: got cfg_ready=%b ch_ready=%b required 1 0000", cfg_ready, ch_ready);
        end
        n_cmp++;
        if (stat_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_stat: got %0d required 0", stat_count);
        end
    endtask

    task automatic test_default_pattern();
        logic [3:0] bits = 4'b1011;
        logic       d;
        logic [CH_W-1:0] c;
        apply_reset();
        for (int i = 3; i >= 0; i--) begin
            send_bit(0, bits[i], d, c);
            n_cmp++;
            if (d !== (i == 0)) begin
                n_err++;
                $display("FAIL default_bit%0d: got det=%b required %b", 3 - i, d, (i == 0));
            end
        end
        n_cmp++;
        if (c !== 2'd0) begin
            n_err++;
            $display("FAIL default_det_ch: got %0d required 0", c);
        end
        @(negedge clock);
        n_cmp++;
        if (det_valid !== 1'b0) begin
            n_err++;
            $display("FAIL default_one_cycle: got det_valid=%b required 0", det_valid);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] stream = 7'b1011011;
        logic       d;
        logic [CH_W-1:0] c;
        int         hits;
        apply_reset();
        hits = 0;
        for (int i = 0; i < 7; i++) begin
            send_bit(0, stream[6 - i], d, c);
            if (d === 1'b1) hits++;
            n_cmp++;
            if (d !== (i == 3 || i == 6)) begin
                n_err++;
                $display("FAIL overlap_on_bit%0d: got det=%b required %b", i, d, (i == 3 || i == 6));
            end
        end
        n_cmp++;
        if (hits != 2) begin
            n_err++;
            $display("FAIL overlap_on_count: got %0d required 2", hits);
        end
`ifdef SEQ_DET_HITCNT_EN
        stat_sel = 2'd0;
        #1;
        n_cmp++;
        if (stat_count !== 8'd2) begin
            n_err++;
            $display("FAIL hitcnt_ch0: got %0d required 2", stat_count);
        end
`endif
        do_cfg(4'b1011, 1'b0);
        hits = 0;
        for (int i = 0; i < 7; i++) begin
            send_bit(0, stream[6 - i], d, c);
            if (d === 1'b1) hits++;
            n_cmp++;
            if (d !== (i == 3)) begin
                n_err++;
                $display("FAIL overlap_off_bit%0d: got det=%b required %b", i, d, (i == 3));
            end
        end
        n_cmp++;
        if (hits != 1) begin
            n_err++;
            $display("FAIL overlap_off_count: got %0d required 1", hits);
        end
    endtask

    task automatic test_round_robin();
        int exp_all[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_drop[4] = '{0, 2, 3, 0};
        apply_reset();
        ch_bit   = '0;
        ch_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (ch_ready !== (4'b0001 << exp_all[i])) begin
                n_err++;
                $display("FAIL rr_all_grant%0d: got %b required ch%0d", i, ch_ready, exp_all[i]);
            end
            @(negedge clock);
        end
        ch_valid = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (ch_ready !== (4'b0001 << exp_drop[i])) begin
                n_err++;
                $display("FAIL rr_drop_grant%0d: got %b required ch%0d", i, ch_ready, exp_drop[i]);
            end
            @(negedge clock);
        end
        ch_valid = '0;
    endtask

    task automatic test_interleave();
        logic [3:0] bits = 4'b1011;
        logic       d;
        logic [CH_W-1:0] c;
        int         hits;
        apply_reset();
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                send_bit(k * 2, bits[3 - i], d, c);
                if (d === 1'b1) hits++;
                n_cmp++;
                if (d !== (i == 3) || (d === 1'b1 && c !== CH_W'(k * 2))) begin
                    n_err++;
                    $display("FAIL interleave_ch%0d_bit%0d: got det=%b ch=%0d required det=%b ch=%0d",
                             k * 2, i, d, c, (i == 3), k * 2);
                end
            end
        end
        n_cmp++;
        if (hits != 2) begin
            n_err++;
            $display("FAIL interleave_count: got %0d required 2", hits);
        end
    endtask

    task automatic test_reconfig();
        logic [2:0] pre  = 3'b101;
        logic [5:0] post = 6'b100110;
        logic       d;
        logic [CH_W-1:0] c;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            send_bit(1, pre[2 - i], d, c);
            n_cmp++;
            if (d !== 1'b0) begin
                n_err++;
                $display("FAIL reconfig_pre_bit%0d: got det=%b required 0", i, d);
            end
        end
        do_cfg(4'b0110, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send_bit(1, post[5 - i], d, c);
            n_cmp++;
            if (d !== (i == 5) || (d === 1'b1 && c !== 2'd1)) begin
                n_err++;
                $display("FAIL reconfig_post_bit%0d: got det=%b ch=%0d required det=%b ch=1", i, d, c, (i == 5));
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [3:0] bits = 4'b0101;
        logic [3:0] tail = 4'b1011;
        logic       d;
        logic [CH_W-1:0] c;
        apply_reset();
        do_cfg(4'b0101, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_bit(3, bits[3 - i], d, c);
            n_cmp++;
            if (d !== (i == 3) || (d === 1'b1 && c !== 2'd3)) begin
                n_err++;
                $display("FAIL midrst_pre_bit%0d: got det=%b ch=%0d required det=%b ch=3", i, d, c, (i == 3));
            end
        end
        #2;
        reset    = 1'b0;
        stat_sel = 2'd3;
        #1;
        n_cmp++;
        if (det_valid !== 1'b0 || det_ch !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_det_async: got valid=%b ch=%0d required 0 0", det_valid, det_ch);
        end
        n_cmp++;
        if (stat_count !== 8'd0) begin
            n_err++;
            $display("FAIL midrst_stat_ch3: got %0d required 0", stat_count);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_bit(3, tail[3 - i], d, c);
            n_cmp++;
            if (d !== (i == 3) || (d === 1'b1 && c !== 2'd3)) begin
                n_err++;
                $display("FAIL midrst_post_bit%0d: got det=%b ch=%0d required det=%b ch=3", i, d, c, (i == 3));
            end
        end
`ifdef SEQ_DET_HITCNT_EN
        #1;
        n_cmp++;
        if (stat_count !== 8'd1) begin
            n_err++;
            $display("FAIL hitcnt_ch3: got %0d required 1", stat_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_default_pattern();
        test_overlap();
        test_round_robin();
        test_interleave();
        test_reconfig();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Time-multiplexes NUM_CH serial bit-streams onto one shared pattern-match datapath, a Moore-style PAT_W-bit sequence detector.
- Per-channel history is held as context. A round-robin arbiter grants one channel bit per cycle.
- A config port loads the pattern and overlap mode, then flushes all channel contexts.
- Sits between the serial input sources and downstream detection logic.

Parameters:
- NUM_CH, 4, number of requesting serial channels (2..16)
- PAT_W, 4, pattern length in bits (2..8)
- DEFAULT_PAT, 4'b1011, pattern loaded at reset (PAT_W bits)
- CH_W, $clog2(NUM_CH), channel index width (derived, min 1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- ch_valid  in  NUM_CH  channel i has a bit to offer
- ch_bit  in  NUM_CH  channel i serial data bit
- ch_ready  out  NUM_CH  one-hot grant; transfer on ch_valid[i]&ch_ready[i]
- cfg_valid  in  1  config request
- cfg_pattern  in  PAT_W  new pattern, MSB = oldest bit
- cfg_overlap  in  1  1 = overlapping detection, 0 = clear context after hit
- cfg_ready  out  1  config accepted when cfg_valid&cfg_ready
- det_valid  out  1  one-cycle detection pulse (registered)
- det_ch  out  CH_W  channel that matched, valid with det_valid
- stat_sel  in  CH_W  channel select for hit-count readback
- stat_count  out  8  hit count of channel stat_sel (see Optional Feature)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, pattern=DEFAULT_PAT, overlap=1.
  - All histories and fill counts = 0; rr pointer = NUM_CH-1, so ch0 has first priority.
  - det_valid=0, det_ch=0, stat_count=0.
- FSM states:
  - IDLE: no ch_valid set. Goes to RUN when any ch_valid=1. Goes to FLUSH on cfg accept.
  - RUN: grants channels. Goes to IDLE when ch_valid==0. Goes to FLUSH on cfg accept.
  - FLUSH: lasts exactly NUM_CH cycles. Clears context of channel k in flush cycle k (k=0..NUM_CH-1), one context write per cycle. Then goes to IDLE.
- Config handshake:
  - cfg_ready=1 combinationally in IDLE and RUN; 0 in FLUSH.
  - Config has priority over channel traffic. In the accept cycle all ch_ready=0, and pattern/overlap load at the clock edge.
  - Pattern in use is stable for the whole FLUSH.
- Arbiter:
  - Combinational one-hot ch_ready. It is the first ch_valid at or after rr+1, modulo NUM_CH.
  - ch_ready is all-zero in FLUSH or during a cfg accept.
  - On a transfer, rr takes the granted index. With no transfer, rr holds.
  - Sources may drop ch_valid without a transfer.
- Context per channel:
  - hist[PAT_W-1:0], shifted left with the new bit inserted at the LSB.
  - fill count, saturating at PAT_W.
- Match:
  - Evaluated on the transfer cycle: fill >= PAT_W-1 and {hist[PAT_W-2:0], bit} == pattern.
  - det_valid=1 and det_ch=granted index in the following cycle, for exactly one cycle. Latency is 1 cycle from handshake.
  - No match: det_valid=0.
- Overlap:
  - overlap=1: context shifts normally after a hit.
  - overlap=0: hist and fill are cleared at the hit edge instead of shifting.
- Simultaneous events:
  - A cfg accept in the same cycle as a pending det_valid does not suppress that det_valid.
  - At most one transfer per cycle.
- Reset mid-FLUSH or mid-stream: immediate return to the reset values above. A partial flush is not resumed.

Optional Feature:
- Macro: SEQ_DET_HITCNT_EN.
- Defined:
  - Per-channel 8-bit hit counter, incremented on every detection and saturating at 255.
  - Counter is cleared by reset and by that channel's FLUSH cycle.
  - stat_count = counter[stat_sel], combinational.
- Undefined: no counters are built and stat_count is tied to 0. The port list is unchanged.

Test Plan:
- Default pattern 1011: ch0 only, bits 1,0,1,1 -> det_valid=1 with det_ch=0 one cycle after the 4th handshake; no pulse before that.
- Overlap on, ch0 bits 1,0,1,1,0,1,1 -> two pulses (after bits 4 and 7). Reconfigure with overlap=0, same stream -> one pulse only.
- All four ch_valid held high -> grants 0,1,2,3,0,1 each one-hot. Then drop ch1 -> order 0,2,3,0.
- ch0 and ch2 interleaved, each sending 1011 -> exactly two pulses, det_ch=0 then det_ch=2, with no cross-channel contamination.
- ch1 fed 1,0,1; then cfg 0110 with overlap=0 -> cfg_ready=1 in the accept cycle, then 4 cycles with cfg_ready=0 and ch_ready=0. Next ch1 bits 1,0 -> no pulse; ch1 0,1,1,0 -> pulse.
- Reset pulled low mid-stream (ch3 fed 1,0,1) -> det_valid=0 immediately and pattern back to 1011. After release, ch3 bit 1 -> no pulse.
  - With SEQ_DET_HITCNT_EN, stat_count for ch3 reads 0.
